// File: rtl/present_sbox_serial_pkg.sv
// present_sbox_serial_pkg
//   Shared types and tables for the serial PRESENT S-box layer.
//   - state_e : controller states
//   - SBOX    : forward 4-bit S-box, entry n at bits [4n+3:4n]
//   - SBOX_INV: inverse table, present only with PRESENT_INV_SBOX_EN
//   - sbox4() : single-nibble lookup
//   Optional feature macro: PRESENT_INV_SBOX_EN
package present_sbox_serial_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   // Forward S-box, x=0..F -> C 5 6 B 9 0 A D 3 E F 8 4 7 1 2 (x=0 in the LSBs)
   localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;

`ifdef PRESENT_INV_SBOX_EN
   // Inverse S-box, x=0..F -> 5 E F 8 C 1 2 D B 4 6 3 0 7 9 A
   localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;

   function automatic logic [3:0] sbox4(input logic [3:0] nib, input logic inv);
      return inv ? SBOX_INV[{nib, 2'b00} +: 4] : SBOX[{nib, 2'b00} +: 4];
   endfunction
`else
   function automatic logic [3:0] sbox4(input logic [3:0] nib);
      return SBOX[{nib, 2'b00} +: 4];
   endfunction
`endif

endpackage

// File: rtl/present_sbox_serial_if.sv
// present_sbox_serial_if
//   Input and output valid/ready channels of the serial S-box layer.
//   master: producer/consumer side (testbench or round datapath)
//   slave : the S-box layer itself
//   Signals: in_valid, in_ready, state_in, out_valid, out_ready, state_out
interface present_sbox_serial_if #(
   parameter int STATE_W = 64
);
   logic               in_valid;
   logic               in_ready;
   logic [STATE_W-1:0] state_in;
   logic               out_valid;
   logic               out_ready;
   logic [STATE_W-1:0] state_out;

   modport master (
      output in_valid, state_in, out_ready,
      input  in_ready, out_valid, state_out
   );

   modport slave (
      input  in_valid, state_in, out_ready,
      output in_ready, out_valid, state_out
   );
endinterface

// File: rtl/present_sbox_serial_sbox4.sv
// present_sbox_serial_sbox4
//   Combinational single-nibble PRESENT S-box.
//   nib_i : nibble in
//   inv_i : 1 = inverse table (only with PRESENT_INV_SBOX_EN)
//   nib_o : substituted nibble
module present_sbox_serial_sbox4
   import present_sbox_serial_pkg::*;
(
   input  logic [3:0] nib_i,
`ifdef PRESENT_INV_SBOX_EN
   input  logic       inv_i,
`endif
   output logic [3:0] nib_o
);

`ifdef PRESENT_INV_SBOX_EN
   assign nib_o = sbox4(nib_i, inv_i);
`else
   assign nib_o = sbox4(nib_i);
`endif

endmodule

// File: rtl/present_sbox_serial.sv
// present_sbox_serial
//   Serial PRESENT S-box layer: LANES nibbles substituted per cycle through a
//   rotating shift register, NCYC = STATE_W/(4*LANES) cycles per state.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   inv   : inverse S-box select, sampled on accept (only with PRESENT_INV_SBOX_EN)
//   bus   : input/output valid/ready channels (slave modport)
//   busy  : substitution in progress
//
//   state | meaning
//   IDLE  | waiting for a state, in_ready=1
//   BUSY  | rotating and substituting LANES nibbles per cycle
//   DONE  | result presented, out_valid=1 until out_ready
module present_sbox_serial
   import present_sbox_serial_pkg::*;
#(
   parameter int STATE_W = 64,
   parameter int LANES   = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
`ifdef PRESENT_INV_SBOX_EN
   input  logic                      inv,
`endif
   present_sbox_serial_if.slave      bus,
   output logic                      busy
);

   localparam int LW    = 4 * LANES;
   localparam int NCYC  = STATE_W / LW;
   localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [STATE_W-1:0] shift_q;
   logic [STATE_W-1:0] shift_d;
   logic [LW-1:0]      lane_out;
   logic               out_valid_q;
   logic               busy_q;
   logic               in_ready;
   logic               accept;
`ifdef PRESENT_INV_SBOX_EN
   logic               inv_q;
`endif

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      present_sbox_serial_sbox4 u_sbox (
         .nib_i (shift_q[4*k +: 4]),
`ifdef PRESENT_INV_SBOX_EN
         .inv_i (inv_q),
`endif
         .nib_o (lane_out[4*k +: 4])
      );
   end

   // Substituted low chunk re-enters at the top, so after NCYC steps every
   // nibble is back where it started.
   if (NCYC == 1) begin : g_one
      assign shift_d = lane_out;
   end else begin : g_rot
      assign shift_d = {lane_out, shift_q[STATE_W-1:LW]};
   end

   assign in_ready      = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
   assign accept        = bus.in_valid & in_ready;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.state_out = shift_q;
   assign busy          = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef PRESENT_INV_SBOX_EN
         inv_q       <= 1'b0;
`endif
      end else if (accept) begin
         // Covers both IDLE and the DONE->BUSY no-bubble path.
         state_q     <= BUSY;
         cnt_q       <= '0;
         shift_q     <= bus.state_in;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b1;
`ifdef PRESENT_INV_SBOX_EN
         inv_q       <= inv;
`endif
      end else begin
         case (state_q)
            BUSY: begin
               shift_q <= shift_d;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(NCYC - 1)) begin
                  state_q     <= DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_present_sbox_serial.sv
module tb_present_sbox_serial;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   present_sbox_serial_if #(.STATE_W(64)) b64 ();
   present_sbox_serial_if #(.STATE_W(16)) b16 ();
   logic busy64, busy16;
`ifdef PRESENT_INV_SBOX_EN
   logic inv64 = 1'b0;
   logic inv16 = 1'b0;
`endif

   present_sbox_serial #(.STATE_W(64), .LANES(4)) dut64 (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef PRESENT_INV_SBOX_EN
      .inv   (inv64),
`endif
      .bus   (b64),
      .busy  (busy64)
   );

   present_sbox_serial #(.STATE_W(16), .LANES(1)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef PRESENT_INV_SBOX_EN
      .inv   (inv16),
`endif
      .bus   (b16),
      .busy  (busy16)
   );

   logic [63:0] q64[$];
   logic [15:0] q16[$];
   int errs   = 0;
   int checks = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endfunction

   // Scoreboard monitors: pop expected on every output handshake.
   always @(negedge clk) begin
      if (rst_n && b64.out_valid && b64.out_ready) begin
         if (q64.size() == 0) begin
            checks++; errs++;
            $display("FAIL out64_unexpected actual=%h expected=none", b64.state_out);
         end else check("out64", b64.state_out, q64.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && b16.out_valid && b16.out_ready) begin
         if (q16.size() == 0) begin
            checks++; errs++;
            $display("FAIL out16_unexpected actual=%h expected=none", b16.state_out);
         end else check("out16", 64'(b16.state_out), 64'(q16.pop_front()));
      end
   end

   task automatic send64(input logic [63:0] d, input logic [63:0] e);
      bit ok = 0;
      b64.in_valid = 1'b1;
      b64.state_in = d;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (b64.in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errs++;
         $display("FAIL send64_timeout actual=in_ready_low expected=in_ready_high");
      end else q64.push_back(e);
      @(posedge clk); #1;
      b64.in_valid = 1'b0;
   endtask

   task automatic send16(input logic [15:0] d, input logic [15:0] e);
      bit ok = 0;
      b16.in_valid = 1'b1;
      b16.state_in = d;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (b16.in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errs++;
         $display("FAIL send16_timeout actual=in_ready_low expected=in_ready_high");
      end else q16.push_back(e);
      @(posedge clk); #1;
      b16.in_valid = 1'b0;
   endtask

   // Counts negedges with out_valid low, stops at the first high one.
   task automatic wait_out64(output int lat);
      lat = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (b64.out_valid) break;
         lat++;
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_out16(output int lat);
      lat = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (b16.out_valid) break;
         lat++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, nbusy, nnrdy;
      logic [15:0] v16_in  [4];
      logic [15:0] v16_exp [4];
      v16_in  = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
      v16_exp = '{16'hC56B, 16'h90AD, 16'h3EF8, 16'h4712};

      b64.in_valid = 1'b0; b64.state_in = '0; b64.out_ready = 1'b1;
      b16.in_valid = 1'b0; b16.state_in = '0; b16.out_ready = 1'b1;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_in_ready",  64'(b64.in_ready), 64'd1);
      check("rst_out_valid", 64'(b64.out_valid), 64'd0);
      check("rst_busy",      64'(busy64), 64'd0);
      check("rst_state_out", b64.state_out, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic vector and latency
      send64(64'h0123456789ABCDEF, 64'hC56B90AD3EF84712);
      wait_out64(lat);
      check("lat64", 64'(lat), 64'd4);

      // All-zero state: busy and !in_ready for exactly NCYC cycles
      send64(64'h0, 64'hCCCCCCCCCCCCCCCC);
      nbusy = 0; nnrdy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (b64.out_valid) break;
         if (busy64) nbusy++;
         if (busy64 && !b64.in_ready) nnrdy++;
      end
      check("busy_cycles",  64'(nbusy), 64'd4);
      check("nready_cycles", 64'(nnrdy), 64'd4);
      @(posedge clk); #1;

      send64(64'hFEDCBA9876543210, 64'h21748FE3DA09B65C);
      wait_out64(lat);

      // Backpressure in DONE, then DONE->BUSY with no idle cycle
      b64.out_ready = 1'b0;
      send64(64'h1111111111111111, 64'h5555555555555555);
      wait_out64(lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_state_out", b64.state_out, 64'h5555555555555555);
         check("hold_in_ready",  64'(b64.in_ready), 64'd0);
         check("hold_out_valid", 64'(b64.out_valid), 64'd1);
      end
      @(posedge clk); #1;
      b64.out_ready = 1'b1;
      send64(64'hAAAAAAAAAAAAAAAA, 64'hFFFFFFFFFFFFFFFF);
      check("b2b_busy",      64'(busy64), 64'd1);
      check("b2b_out_valid", 64'(b64.out_valid), 64'd0);
      wait_out64(lat);

      // Reset mid-BUSY
      send64(64'h0123456789ABCDEF, 64'hC56B90AD3EF84712);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready",  64'(b64.in_ready), 64'd1);
      check("mid_rst_out_valid", 64'(b64.out_valid), 64'd0);
      check("mid_rst_busy",      64'(busy64), 64'd0);
      check("mid_rst_state_out", b64.state_out, 64'd0);
      q64.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send64(64'hFFFFFFFFFFFFFFFF, 64'h2222222222222222);
      wait_out64(lat);
      check("post_rst_lat", 64'(lat), 64'd4);

      // 16-bit, single lane
      for (int i = 0; i < 4; i++) begin
         send16(v16_in[i], v16_exp[i]);
         wait_out16(lat);
         check("lat16", 64'(lat), 64'd4);
      end

`ifdef PRESENT_INV_SBOX_EN
      inv64 = 1'b1;
      send64(64'hC56B90AD3EF84712, 64'h0123456789ABCDEF);
      @(posedge clk); #1;
      inv64 = 1'b0;
      wait_out64(lat);
      check("inv_lat", 64'(lat), 64'd3);
`endif

      repeat (3) @(posedge clk);
      check("drain64", 64'(q64.size()), 64'd0);
      check("drain16", 64'(q16.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
